// File: rtl/aixh_mxc_inner_ptile_gen2.sv
// Weight-stationary inner MAC tile: YCELLS x XCELLS cells with shadow/active weights,
// optional internal input skew / output deskew, and swap handshaking against in-flight vectors.

module aixh_mxc_inner_ptile_gen2_dly #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] pipe_q [D];
    logic [W-1:0] pipe_d [D];

    always_comb begin
        pipe_d[0] = d;
        for (int unsigned i = 1; i < D; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < D; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign q = pipe_q[D-1];
endmodule

module aixh_mxc_inner_ptile_gen2 #(
    parameter int unsigned XCELLS  = 4,
    parameter int unsigned YCELLS  = 4,
    parameter int unsigned ADW     = 8,
    parameter int unsigned WDW     = 8,
    parameter int unsigned PSW     = 24,
    parameter int unsigned SKEW_EN = 1
) (
    input  logic                    aixh_core_clk2x,
    input  logic                    aixh_core_rst2x,
    input  logic [XCELLS-1:0]       i_wld_vld,
    input  logic [XCELLS*WDW-1:0]   i_wld_dat,
    input  logic                    i_wswap,
    input  logic                    i_act_vld,
    input  logic [YCELLS*ADW-1:0]   i_act_dat,
    input  logic [XCELLS*PSW-1:0]   i_psum_dat,
    output logic                    o_act_rdy,
    output logic                    o_psum_vld,
    output logic [XCELLS*PSW-1:0]   o_psum_dat,
    output logic                    o_busy
);
    localparam int unsigned LAT = (SKEW_EN != 0) ? XCELLS + YCELLS - 1 : YCELLS;
    localparam int unsigned CW  = $clog2(LAT + 1);
    localparam int unsigned AXW = (XCELLS > 1) ? XCELLS - 1 : 1;
    localparam int unsigned MW  = ADW + WDW;

    typedef enum logic {IDLE = 1'b0, SWAP_WAIT = 1'b1} state_e;

    state_e          state_q, state_d;
    logic            rdy_q, rdy_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LAT-1:0]  vld_q, vld_d;
    logic            accept_c, swap_c;

    logic [WDW-1:0]  w_sh_q  [YCELLS][XCELLS];
    logic [WDW-1:0]  w_sh_d  [YCELLS][XCELLS];
    logic [WDW-1:0]  w_act_q [YCELLS][XCELLS];
    logic [WDW-1:0]  w_act_d [YCELLS][XCELLS];
    logic [ADW-1:0]  a_q     [YCELLS][AXW];
    logic [ADW-1:0]  a_d     [YCELLS][AXW];
    logic [PSW-1:0]  ps_q    [YCELLS][XCELLS];
    logic [PSW-1:0]  ps_d    [YCELLS][XCELLS];

    logic [ADW-1:0]  act_in_c [YCELLS];
    logic [ADW-1:0]  act_sk   [YCELLS];
    logic [PSW-1:0]  ps_in_c  [XCELLS];
    logic [PSW-1:0]  ps_sk    [XCELLS];
    logic [ADW-1:0]  ain_c    [YCELLS][XCELLS];
    logic [PSW-1:0]  pin_c    [YCELLS][XCELLS];
    logic signed [MW-1:0] prod_c;

    assign accept_c   = i_act_vld & rdy_q;
    assign o_act_rdy  = rdy_q;
    assign o_psum_vld = vld_q[LAT-1];
    assign o_busy     = busy_q;

    // Swap control: swap only once the array holds no in-flight vector
    always_comb begin
        state_d = state_q;
        swap_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_wswap) begin
                    if (cnt_q == '0 && !accept_c) swap_c = 1'b1;
                    else                          state_d = SWAP_WAIT;
                end
            end
            SWAP_WAIT: begin
                if (cnt_q == '0) begin
                    swap_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_d  = (state_d == IDLE);
        cnt_d  = cnt_q + CW'(accept_c) - CW'(vld_q[LAT-1]);
        busy_d = (cnt_d != '0);
        vld_d[0] = accept_c;
        for (int unsigned i = 1; i < LAT; i++) vld_d[i] = vld_q[i-1];
    end

    // Shadow weights shift down per column; swap copies the pre-shift shadow
    always_comb begin
        w_sh_d = w_sh_q;
        for (int unsigned x = 0; x < XCELLS; x++) begin
            if (i_wld_vld[x]) begin
                w_sh_d[0][x] = i_wld_dat[x*WDW +: WDW];
                for (int unsigned y = 1; y < YCELLS; y++) w_sh_d[y][x] = w_sh_q[y-1][x];
            end
        end
        if (swap_c) w_act_d = w_sh_q;
        else        w_act_d = w_act_q;
    end

    // With internal skew, unaccepted data is zeroed so the array only sees real vectors
    always_comb begin
        for (int unsigned y = 0; y < YCELLS; y++)
            act_in_c[y] = (SKEW_EN == 0 || accept_c) ? i_act_dat[y*ADW +: ADW] : '0;
        for (int unsigned x = 0; x < XCELLS; x++)
            ps_in_c[x] = (SKEW_EN == 0 || accept_c) ? i_psum_dat[x*PSW +: PSW] : '0;
    end

    for (genvar y = 0; y < YCELLS; y++) begin : g_arow
        if (SKEW_EN != 0 && y > 0) begin : g_dly
            aixh_mxc_inner_ptile_gen2_dly #(.W(ADW), .D(y)) u_dly (
                .clk (aixh_core_clk2x),
                .rst (aixh_core_rst2x),
                .d   (act_in_c[y]),
                .q   (act_sk[y])
            );
        end else begin : g_thru
            assign act_sk[y] = act_in_c[y];
        end
    end

    for (genvar x = 0; x < XCELLS; x++) begin : g_pcol
        if (SKEW_EN != 0 && x > 0) begin : g_dly
            aixh_mxc_inner_ptile_gen2_dly #(.W(PSW), .D(x)) u_dly (
                .clk (aixh_core_clk2x),
                .rst (aixh_core_rst2x),
                .d   (ps_in_c[x]),
                .q   (ps_sk[x])
            );
        end else begin : g_thru
            assign ps_sk[x] = ps_in_c[x];
        end

        if (SKEW_EN != 0 && x < XCELLS - 1) begin : g_desk
            aixh_mxc_inner_ptile_gen2_dly #(.W(PSW), .D(XCELLS - 1 - x)) u_dly (
                .clk (aixh_core_clk2x),
                .rst (aixh_core_rst2x),
                .d   (ps_q[YCELLS-1][x]),
                .q   (o_psum_dat[x*PSW +: PSW])
            );
        end else begin : g_out
            assign o_psum_dat[x*PSW +: PSW] = ps_q[YCELLS-1][x];
        end
    end

    // MAC cells: activation flows right, partial sums flow down
    always_comb begin
        prod_c = '0;
        a_d    = a_q;
        for (int unsigned y = 0; y < YCELLS; y++) begin
            ain_c[y][0] = act_sk[y];
            for (int unsigned x = 1; x < XCELLS; x++) ain_c[y][x] = a_q[y][x-1];
        end
        for (int unsigned x = 0; x < XCELLS; x++) begin
            pin_c[0][x] = ps_sk[x];
            for (int unsigned y = 1; y < YCELLS; y++) pin_c[y][x] = ps_q[y-1][x];
        end
        for (int unsigned y = 0; y < YCELLS; y++) begin
            for (int unsigned x = 0; x < XCELLS; x++) begin
                prod_c      = $signed(ain_c[y][x]) * $signed(w_act_q[y][x]);
                ps_d[y][x]  = pin_c[y][x] + PSW'(prod_c);
            end
            for (int unsigned x = 0; x + 1 < XCELLS; x++) a_d[y][x] = ain_c[y][x];
        end
    end

    always_ff @(posedge aixh_core_clk2x) begin
        if (aixh_core_rst2x) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            vld_q   <= '0;
            for (int unsigned y = 0; y < YCELLS; y++) begin
                for (int unsigned x = 0; x < XCELLS; x++) begin
                    w_sh_q[y][x]  <= '0;
                    w_act_q[y][x] <= '0;
                    ps_q[y][x]    <= '0;
                end
                for (int unsigned x = 0; x < AXW; x++) a_q[y][x] <= '0;
            end
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            w_sh_q  <= w_sh_d;
            w_act_q <= w_act_d;
            a_q     <= a_d;
            ps_q    <= ps_d;
        end
    end
endmodule

// File: tb/tb_aixh_mxc_inner_ptile_gen2.sv
// Directed bench for aixh_mxc_inner_ptile_gen2: skewed default tile plus a SKEW_EN=0 instance.

module tb_aixh_mxc_inner_ptile_gen2;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wld_vld;
    logic [31:0] wld_dat;
    logic        wswap;
    logic        act_vld, act_vld0;
    logic [31:0] act_dat, act_dat0;
    logic [95:0] psum_in, psum_in0;
    logic        act_rdy, act_rdy0;
    logic        psum_vld, psum_vld0;
    logic [95:0] psum_dat, psum_dat0;
    logic        busy, busy0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aixh_mxc_inner_ptile_gen2 dut (
        .aixh_core_clk2x (clk),
        .aixh_core_rst2x (rst),
        .i_wld_vld       (wld_vld),
        .i_wld_dat       (wld_dat),
        .i_wswap         (wswap),
        .i_act_vld       (act_vld),
        .i_act_dat       (act_dat),
        .i_psum_dat      (psum_in),
        .o_act_rdy       (act_rdy),
        .o_psum_vld      (psum_vld),
        .o_psum_dat      (psum_dat),
        .o_busy          (busy)
    );

    aixh_mxc_inner_ptile_gen2 #(.SKEW_EN(0)) dut0 (
        .aixh_core_clk2x (clk),
        .aixh_core_rst2x (rst),
        .i_wld_vld       (wld_vld),
        .i_wld_dat       (wld_dat),
        .i_wswap         (wswap),
        .i_act_vld       (act_vld0),
        .i_act_dat       (act_dat0),
        .i_psum_dat      (psum_in0),
        .o_act_rdy       (act_rdy0),
        .o_psum_vld      (psum_vld0),
        .o_psum_dat      (psum_dat0),
        .o_busy          (busy0)
    );

    function automatic logic [31:0] pack_act(input int a0, input int a1, input int a2, input int a3);
        return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [95:0] pack_ps(input int p0, input int p1, input int p2, input int p3);
        return {24'(p3), 24'(p2), 24'(p1), 24'(p0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Beat b lands in row 3-b after four beats
    task automatic load_w(input bit ident, input logic [7:0] v);
        for (int b = 0; b < 4; b++) begin
            wld_vld = 4'hF;
            for (int x = 0; x < 4; x++)
                wld_dat[x*8 +: 8] = ident ? ((x == 3 - b) ? 8'd1 : 8'd0) : v;
            tick();
        end
        wld_vld = 4'h0;
    endtask

    task automatic do_swap();
        wswap = 1'b1;
        tick();
        wswap = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        rst = 1'b1; wld_vld = '0; wld_dat = '0; wswap = 1'b0;
        act_vld = 1'b0; act_dat = '0; psum_in = '0;
        act_vld0 = 1'b0; act_dat0 = '0; psum_in0 = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_vld", psum_vld, 0);
        chk("rst_dat", psum_dat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", act_rdy, 1);
        chk("rst_rdy0", act_rdy0, 1);

        // Identity weights, single vector, latency 7
        load_w(1'b1, 8'h00);
        do_swap();
        act_vld = 1'b1; act_dat = pack_act(1, 2, 3, 4); psum_in = '0;
        tick();
        act_vld = 1'b0;
        chk("id_busy", busy, 1);
        repeat (5) tick();
        chk("id_vld_early", psum_vld, 0);
        tick();
        chk("id_vld", psum_vld, 1);
        chk("id_dat", psum_dat, pack_ps(1, 2, 3, 4));
        tick();
        chk("id_vld_after", psum_vld, 0);
        chk("id_busy_after", busy, 0);

        // Eight back-to-back vectors with nonzero cascade psum
        for (int t = 0; t < 16; t++) begin
            if (t < 8) begin
                act_vld = 1'b1;
                act_dat = pack_act(4*t + 1, 4*t + 2, 4*t + 3, 4*t + 4);
                psum_in = pack_ps(16*t, 16*t + 1, 16*t + 2, 16*t + 3);
            end else begin
                act_vld = 1'b0;
            end
            tick();
            if (t + 1 >= 7 && t + 1 <= 14) begin
                n = t + 1 - 7;
                chk("b2b_vld", psum_vld, 1);
                chk("b2b_dat", psum_dat, pack_ps(20*n + 1, 20*n + 3, 20*n + 5, 20*n + 7));
            end else begin
                chk("b2b_idle", psum_vld, 0);
            end
        end
        chk("b2b_busy_end", busy, 0);
        psum_in = '0;

        // Swap requested with three vectors in flight; stalled vectors must be ignored
        load_w(1'b0, 8'd2);
        for (int t = 0; t < 18; t++) begin
            wswap = (t == 2);
            if (t < 3) begin
                act_vld = 1'b1; act_dat = pack_act(t + 1, t + 2, t + 3, t + 4);
            end else if (t <= 10) begin
                act_vld = 1'b1; act_dat = pack_act(9, 9, 9, 9);
            end else if (t == 11) begin
                act_vld = 1'b1; act_dat = pack_act(1, 2, 3, 4);
            end else begin
                act_vld = 1'b0;
            end
            tick();
            if (t + 1 >= 3 && t + 1 <= 10) chk("sw_rdy_low", act_rdy, 0);
            if (t + 1 == 11) chk("sw_rdy_high", act_rdy, 1);
            if (t + 1 >= 7 && t + 1 <= 9) begin
                n = t + 1 - 7;
                chk("sw_old_vld", psum_vld, 1);
                chk("sw_old_dat", psum_dat, pack_ps(n + 1, n + 2, n + 3, n + 4));
            end else if (t + 1 == 18) begin
                chk("sw_new_vld", psum_vld, 1);
                chk("sw_new_dat", psum_dat, pack_ps(20, 20, 20, 20));
            end else begin
                chk("sw_idle", psum_vld, 0);
            end
        end
        wswap = 1'b0;

        // Most negative operands wrap the 24-bit sum
        load_w(1'b0, 8'h80);
        do_swap();
        act_vld = 1'b1; act_dat = pack_act(-128, -128, -128, -128);
        psum_in = pack_ps(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
        tick();
        act_vld = 1'b0;
        repeat (6) tick();
        chk("wrap_vld", psum_vld, 1);
        chk("wrap_dat", psum_dat, pack_ps(24'h80FFFF, 24'h80FFFF, 24'h80FFFF, 24'h80FFFF));
        tick();

        // Reset with vectors in flight
        for (int t = 0; t < 3; t++) begin
            act_vld = 1'b1; act_dat = pack_act(1, 1, 1, 1); psum_in = pack_ps(5, 5, 5, 5);
            tick();
        end
        act_vld = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("mrst_rdy", act_rdy, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_dat", psum_dat, 0);
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (psum_vld) seen++;
        end
        chk("mrst_no_vld", seen, 0);
        act_vld = 1'b1; act_dat = pack_act(5, 6, 7, 8); psum_in = pack_ps(10, 20, 30, 40);
        tick();
        act_vld = 1'b0;
        repeat (6) tick();
        chk("mrst_new_vld", psum_vld, 1);
        chk("mrst_new_dat", psum_dat, pack_ps(10, 20, 30, 40));
        psum_in = '0;

        // Unskewed instance with caller-skewed identity vector
        load_w(1'b1, 8'h00);
        do_swap();
        for (int t = 0; t < 7; t++) begin
            act_vld0 = (t == 0);
            psum_in0 = '0;
            case (t)
                0:       act_dat0 = pack_act(1, 0, 0, 0);
                1:       act_dat0 = pack_act(0, 2, 0, 0);
                2:       act_dat0 = pack_act(0, 0, 3, 0);
                3:       act_dat0 = pack_act(0, 0, 0, 4);
                default: act_dat0 = '0;
            endcase
            tick();
            if (t + 1 == 3) chk("ns_vld_early", psum_vld0, 0);
            if (t + 1 == 4) chk("ns_vld", psum_vld0, 1);
            if (t + 1 == 5) chk("ns_vld_one", psum_vld0, 0);
            if (t + 1 >= 4) begin
                n = t + 1 - 4;
                chk("ns_col", psum_dat0[n*24 +: 24], 24'(n + 1));
            end
        end
        chk("ns_busy_end", busy0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
